// File: rtl/counter_arb_pkg.sv
// counter_arb_pkg: shared types and constants for the counter run arbiter.
//   arb_state_e : controller states (idle / clear counter / count / report done)
//   NUM_REQ     : number of requesters sharing the counter
//   LIM_MAX     : largest usable run length for the default 4-bit counter
package counter_arb_pkg;

  localparam int unsigned NUM_REQ = 2;
  localparam int unsigned LIM_MAX = 14;

  typedef enum logic [1:0] {
    StIdle,
    StClear,
    StRun,
    StFinish
  } arb_state_e;

endpackage

// File: rtl/rr_pick2.sv
// rr_pick2: combinational two-way round-robin picker.
//   i_req   : request vector, bit i = requester i
//   i_last  : index of the requester served most recently
//   o_win   : one-hot winner (zero when nobody requests)
//   o_valid : at least one request is present
module rr_pick2 (
  input  logic [1:0] i_req,
  input  logic       i_last,
  output logic [1:0] o_win,
  output logic       o_valid
);

  always_comb begin
    o_valid = |i_req;
    o_win   = 2'b00;
    unique case (i_req)
      2'b00: o_win = 2'b00;
      2'b01: o_win = 2'b01;
      2'b10: o_win = 2'b10;
      // On a tie the requester that was not served last goes next.
      2'b11: o_win = i_last ? 2'b01 : 2'b10;
    endcase
  end

endmodule

// File: rtl/counter_run_arbiter.sv
// counter_run_arbiter: shares one up-counter between two requesters. The winner of
// a round-robin pick gets the counter cleared, then enabled until it reaches the
// requested limit, after which DONE pulses for one cycle to the winner.
//   i_clk      : system clock (the counter shares it)
//   i_clr      : synchronous active-low reset
//   i_req      : level-sensitive run requests
//   i_lim0/1   : requested run length per requester, sampled at grant
//   i_q        : current counter value
//   o_e        : counter enable (combinational, stops exactly at the limit)
//   o_cnt_clr  : counter clear, active-low
//   o_gnt      : registered one-hot grant
//   o_done     : registered one-cycle completion pulse
//   o_busy     : controller is not idle
module counter_run_arbiter
  import counter_arb_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic               i_clk,
  input  logic               i_clr,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [WIDTH-1:0]   i_lim0,
  input  logic [WIDTH-1:0]   i_lim1,
  input  logic [WIDTH-1:0]   i_q,
  output logic               o_e,
  output logic               o_cnt_clr,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [NUM_REQ-1:0] o_done,
  output logic               o_busy
);

  // The counter self-clears at all-ones, so the top usable limit is all-ones minus one.
  localparam logic [WIDTH-1:0] LimMax = {{(WIDTH-1){1'b1}}, 1'b0};

  arb_state_e           r_state;
  arb_state_e           w_state_next;
  logic [WIDTH-1:0]     r_lim;
  logic                 r_last;
  logic [NUM_REQ-1:0]   r_gnt;
  logic [NUM_REQ-1:0]   r_done;

  logic [NUM_REQ-1:0]   w_pick;
  logic                 w_pick_valid;
  logic [WIDTH-1:0]     w_lim_sel;
  logic [WIDTH-1:0]     w_lim_clamped;
  logic                 w_at_lim;

  rr_pick2 u_pick (
    .i_req   (i_req),
    .i_last  (r_last),
    .o_win   (w_pick),
    .o_valid (w_pick_valid)
  );

  assign w_lim_sel     = w_pick[1] ? i_lim1 : i_lim0;
  assign w_lim_clamped = (w_lim_sel == '1) ? LimMax : w_lim_sel;
  assign w_at_lim      = (i_q == r_lim);

  // State register plus the registers that change alongside state transitions.
  always_ff @(posedge i_clk) begin
    if (!i_clr) begin
      r_state <= StIdle;
      r_lim   <= '0;
      r_last  <= 1'b1;
      r_gnt   <= '0;
      r_done  <= '0;
    end else begin
      r_state <= w_state_next;
      unique case (r_state)
        StIdle: begin
          if (w_pick_valid) begin
            r_gnt <= w_pick;
            r_lim <= w_lim_clamped;
          end
        end
        StRun: begin
          if (w_at_lim) r_done <= r_gnt;
        end
        StFinish: begin
          r_done <= '0;
          r_gnt  <= '0;
          r_last <= r_gnt[1];
        end
        default: ;
      endcase
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:   if (w_pick_valid) w_state_next = StClear;
      StClear:  w_state_next = StRun;
      StRun:    if (w_at_lim) w_state_next = StFinish;
      StFinish: w_state_next = StIdle;
      default:  w_state_next = StIdle;
    endcase
  end

  // Outputs. The clear pin also follows i_clr so the counter is held clear during reset.
  always_comb begin
    o_e       = (r_state == StRun) && !w_at_lim;
    o_cnt_clr = i_clr && (r_state != StClear);
    o_busy    = (r_state != StIdle);
    o_gnt     = r_gnt;
    o_done    = r_done;
  end

endmodule

// File: tb/tb_counter_run_arbiter.sv
module tb_counter_run_arbiter;
  import counter_arb_pkg::*;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic [1:0] req = 2'b00;
  logic [3:0] lim0 = 4'd0;
  logic [3:0] lim1 = 4'd0;
  logic [3:0] q = 4'd0;
  logic       e;
  logic       cnt_clr;
  logic       busy;
  logic [1:0] gnt;
  logic [1:0] done;

  int vectors = 0;
  int miscompares = 0;
  int last_srv = 1;   // model of the round-robin pointer
  bit mon_en = 1'b0;

  counter_run_arbiter #(.WIDTH(4)) dut (
    .i_clk     (clk),
    .i_clr     (clr),
    .i_req     (req),
    .i_lim0    (lim0),
    .i_lim1    (lim1),
    .i_q       (q),
    .o_e       (e),
    .o_cnt_clr (cnt_clr),
    .o_gnt     (gnt),
    .o_done    (done),
    .o_busy    (busy)
  );

  always #5 clk = ~clk;

  // Behavioural counter: synchronous active-low clear, count when enabled, wraps at all-ones.
  always @(posedge clk) begin
    if (!cnt_clr) q <= 4'd0;
    else if (e)   q <= q + 4'd1;
  end

  // Continuous invariants, sampled away from the active edge.
  always @(negedge clk) begin
    if (mon_en) begin
      vectors++;
      if (e && !(busy && gnt != 2'b00)) begin
        miscompares++;
        $display("FAIL e_outside_run: e=%b busy=%b gnt=%b (e must be 0 when no run)", e, busy, gnt);
      end
      vectors++;
      if ($countones(gnt) > 1 || $countones(done) > 1 || (done != 2'b00 && done != gnt)) begin
        miscompares++;
        $display("FAIL onehot: gnt=%b done=%b (expected one-hot and done==gnt)", gnt, done);
      end
      vectors++;
      if (q == 4'hF) begin
        miscompares++;
        $display("FAIL q_all_ones: q=%h (expected never F)", q);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Applies one request and checks the full run timeline cycle by cycle.
  // Called while the DUT is idle; returns in the idle cycle after FINISH.
  task automatic run_and_check(input logic [1:0] r, input logic [3:0] l0, input logic [3:0] l1,
                               input bit withdraw, input string name);
    int w;
    int lim;
    logic [1:0] oh;
    logic [6:0] got;
    logic [6:0] exp_v;
    logic [3:0] exp_q;
    req  = r;
    lim0 = l0;
    lim1 = l1;
    if (r == 2'b11) w = (last_srv == 1) ? 0 : 1;
    else            w = r[1] ? 1 : 0;
    lim = int'(w == 1 ? l1 : l0);
    if (lim > int'(LIM_MAX)) lim = int'(LIM_MAX);
    oh = (w == 1) ? 2'b10 : 2'b01;
    tick();
    for (int k = 1; k <= lim + 4; k++) begin
      got   = {gnt, done, e, cnt_clr, busy};
      exp_v = {(k <= lim + 3) ? oh : 2'b00,
               (k == lim + 3) ? oh : 2'b00,
               (k >= 2 && k <= lim + 1),
               (k != 1),
               (k <= lim + 3)};
      vectors++;
      if (got !== exp_v) begin
        miscompares++;
        $display("FAIL %s k=%0d lim=%0d {gnt,done,e,cnt_clr,busy}: got %b expected %b",
                 name, k, lim, got, exp_v);
      end
      if (k >= 2) begin
        exp_q = 4'((k - 2 < lim) ? k - 2 : lim);
        vectors++;
        if (q !== exp_q) begin
          miscompares++;
          $display("FAIL %s k=%0d q: got %0d expected %0d", name, k, q, exp_q);
        end
      end
      if (withdraw && k == 3) begin
        req  = 2'b00;
        lim0 = 4'd9;
        lim1 = 4'd9;
      end
      if (k < lim + 4) tick();
    end
    last_srv = w;
  endtask

  task automatic check_idle(input string name);
    logic [6:0] got;
    got = {gnt, done, e, cnt_clr, busy};
    vectors++;
    if (got !== 7'b0000_0_1_0) begin
      miscompares++;
      $display("FAIL %s {gnt,done,e,cnt_clr,busy}: got %b expected 0000010", name, got);
    end
  endtask

  task automatic test_reset();
    logic [6:0] got;
    clr = 1'b0;
    req = 2'b00;
    repeat (3) tick();
    mon_en = 1'b1;
    got = {gnt, done, e, cnt_clr, busy};
    vectors++;
    if (got !== 7'b0) begin
      miscompares++;
      $display("FAIL reset_state: got %b expected 0000000", got);
    end
    clr = 1'b1;
    repeat (2) tick();
    check_idle("post_reset_idle");
    last_srv = 1;
  endtask

  task automatic test_tie_fairness();
    for (int i = 0; i < 4; i++) run_and_check(2'b11, 4'd2, 4'd3, 1'b0, "tie");
    req = 2'b00;
  endtask

  task automatic test_single_run();
    run_and_check(2'b01, 4'd6, 4'd0, 1'b0, "single");
    req = 2'b00;
  endtask

  task automatic test_boundary();
    run_and_check(2'b10, 4'd5, 4'd0, 1'b0, "lim_zero");
    run_and_check(2'b01, 4'd15, 4'd7, 1'b0, "lim_clamp");
    req = 2'b00;
  endtask

  task automatic test_withdraw();
    run_and_check(2'b01, 4'd4, 4'd7, 1'b1, "withdraw");
    req = 2'b00;
  endtask

  task automatic test_random();
    logic [1:0] r;
    for (int i = 0; i < 40; i++) begin
      req = 2'b00;
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
        tick();
        check_idle("rand_gap");
      end
      r = 2'($urandom_range(1, 3));
      run_and_check(r, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                    1'($urandom_range(0, 1)), "random");
    end
    req = 2'b00;
  endtask

  task automatic test_reset_mid_run();
    logic [6:0] got;
    req  = 2'b01;
    lim0 = 4'd10;
    tick();          // grant edge
    repeat (6) tick();
    vectors++;
    if (q !== 4'd5 || e !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_run_setup: q=%0d e=%b expected q=5 e=1", q, e);
    end
    clr = 1'b0;
    tick();
    got = {gnt, done, e, cnt_clr, busy};
    vectors++;
    if (got !== 7'b0 || q !== 4'd0) begin
      miscompares++;
      $display("FAIL mid_run_reset: outs=%b q=%0d expected 0000000 q=0", got, q);
    end
    tick();
    req = 2'b00;
    clr = 1'b1;
    tick();
    check_idle("after_mid_reset");
    last_srv = 1;
    // Pointer must be back to favouring requester 0 on a tie.
    run_and_check(2'b11, 4'd1, 4'd3, 1'b0, "tie_after_reset");
    req = 2'b00;
  endtask

  initial begin
    test_reset();
    test_tie_fairness();
    test_single_run();
    test_boundary();
    test_withdraw();
    test_random();
    test_reset_mid_run();
    tick();
    check_idle("final_idle");
    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
